hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 14 +
 rtl/div_stall_ctrl.sv | 60 ++++++
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the MIPS hazard unit and its divider stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/div_stall_ctrl.sv
// Divider occupancy FSM: IDLE -> BUSY for DIV_CYCLES cycles -> one DONE cycle.
// Start is refused during an exception; exception or reset aborts without a done pulse.
module div_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic div_start_i,
  input  logic except_i,
  output logic div_idle_o,
  output logic div_busy_o,
  output logic div_done_o
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

  div_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (div_start_i && !except_i) begin
            state_q <= BUSY;
            cnt_q   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (except_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        // a start still asserted here belongs to the divide that just finished
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_idle_o = (state_q == IDLE);
  assign div_busy_o = (state_q == BUSY);
  assign div_done_o = done_q & ~rst_i;

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage MIPS hazard unit: D/E forwarding selects, load-use/branch/divide stalls, M-stage exception flush.
// Forwarding, stall and flush are combinational; divider state and stall counter are registered.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic              jrD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic              div_startE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic              exceptM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteW,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushF,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              div_busy,
  output logic              div_done,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic             lwstall, brstall, divstall, div_idle;
  logic             e_hit_d, m_hit_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  div_stall_ctrl #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk_i       (clk),
    .rst_i       (rst),
    .div_start_i (div_startE),
    .except_i    (exceptM),
    .div_idle_o  (div_idle),
    .div_busy_o  (div_busy),
    .div_done_o  (div_done)
  );

  function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] r);
    if (r != '0 && r == writeregM && regwriteM) return FWD_M;
    if (r != '0 && r == writeregW && regwriteW) return FWD_W;
    return FWD_RF;
  endfunction

  assign forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
  assign forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;
  assign forwardaE = fwd_e(rsE);
  assign forwardbE = fwd_e(rtE);

  assign lwstall  = memtoregE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));
  assign e_hit_d  = regwriteE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD));
  assign m_hit_d  = memtoregM && (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD));
  assign brstall  = (branchD || jrD) && (e_hit_d || m_hit_d);
  assign divstall = (div_idle && div_startE) || div_busy;

  // reset flushes every stage; an exception flushes all but W so the faulting-free older op retires
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushF = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (rst) begin
      {flushF, flushD, flushE, flushM, flushW} = 5'b11111;
    end else if (exceptM) begin
      {flushF, flushD, flushE, flushM} = 4'b1111;
    end else begin
      stallF = lwstall || brstall || divstall;
      stallD = lwstall || brstall || divstall;
      stallE = divstall;
      flushE = (lwstall || brstall) && !divstall;
      flushM = divstall;
    end
  end

  assign stall_cnt_d = stall_cnt_q + CNT_W'(stallD);

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector scoreboard bench for hazard_ctrl with DIV_CYCLES=4, CNT_W=3.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       faD;
    logic       fbD;
    logic [1:0] faE;
    logic [1:0] fbE;
    logic       sF;
    logic       sD;
    logic       sE;
    logic [4:0] fl;   // {F,D,E,M,W}
    logic       busy;
    logic       done;
    logic [2:0] cnt;
  } out_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       branchD, jrD, regwriteE, memtoregE, div_startE;
  logic       regwriteM, memtoregM, exceptM, regwriteW;
  logic       forwardaD, forwardbD, stallF, stallD, stallE;
  logic [1:0] forwardaE, forwardbE;
  logic       flushF, flushD, flushE, flushM, flushW, div_busy, div_done;
  logic [2:0] stall_cnt;

  out_t exp_q[$];
  int   id_q[$];
  int   vid = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  out_t act, want;
  int   cur_id;

  hazard_ctrl #(.REG_AW(5), .DIV_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .div_startE(div_startE),
    .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .exceptM(exceptM), .writeregW(writeregW), .regwriteW(regwriteW),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .div_busy(div_busy), .div_done(div_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic fa, input logic fb, input logic [1:0] ea,
                              input logic [1:0] eb, input logic sfd, input logic se,
                              input logic [4:0] fl, input logic bsy, input logic dn,
                              input logic [2:0] c);
    out_t o;
    o.faD = fa;  o.fbD = fb;  o.faE = ea;  o.fbE = eb;
    o.sF = sfd;  o.sD = sfd;  o.sE = se;   o.fl = fl;
    o.busy = bsy; o.done = dn; o.cnt = c;
    return o;
  endfunction

  function automatic out_t idle(input logic [2:0] c);
    return mk(0, 0, 2'b00, 2'b00, 0, 0, 5'b00000, 0, 0, c);
  endfunction

  function automatic out_t divs(input logic bsy, input logic [2:0] c);
    return mk(0, 0, 2'b00, 2'b00, 1, 1, 5'b00010, bsy, 0, c);
  endfunction

  task automatic clr();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0; writeregM = 0; writeregW = 0;
    branchD = 0; jrD = 0; regwriteE = 0; memtoregE = 0; div_startE = 0;
    regwriteM = 0; memtoregM = 0; exceptM = 0; regwriteW = 0;
  endtask

  // queue the expectation for the cycle now being driven, then move to the next cycle
  task automatic expect_out(input out_t e);
    exp_q.push_back(e);
    id_q.push_back(vid);
    vid++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      want   = exp_q.pop_front();
      cur_id = id_q.pop_front();
      act = '{faD: forwardaD, fbD: forwardbD, faE: forwardaE, fbE: forwardbE,
              sF: stallF, sD: stallD, sE: stallE,
              fl: {flushF, flushD, flushE, flushM, flushW},
              busy: div_busy, done: div_done, cnt: stall_cnt};
      n_vec++;
      if (act !== want) begin
        n_bad++;
        $display("FAIL vec%0d: got %b want %b", cur_id, act, want);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    clr();
    rst = 1;
    @(posedge clk); #1;
    expect_out(mk(0, 0, 2'b00, 2'b00, 0, 0, 5'b11111, 0, 0, 0));
    rst = 0;
    expect_out(idle(0));

    // forwarding priority and register-0 exclusion
    rsE = 8; rtE = 8; writeregM = 8; writeregW = 8; regwriteM = 1; regwriteW = 1;
    expect_out(mk(0, 0, 2'b10, 2'b10, 0, 0, 5'b00000, 0, 0, 0));
    regwriteM = 0;
    expect_out(mk(0, 0, 2'b01, 2'b01, 0, 0, 5'b00000, 0, 0, 0));
    rsE = 0;
    expect_out(mk(0, 0, 2'b00, 2'b01, 0, 0, 5'b00000, 0, 0, 0));
    rtD = 8; regwriteM = 1;
    expect_out(mk(0, 1, 2'b00, 2'b10, 0, 0, 5'b00000, 0, 0, 0));

    // load-use
    clr(); memtoregE = 1; rtE = 9; rsD = 9;
    expect_out(mk(0, 0, 2'b00, 2'b00, 1, 0, 5'b00100, 0, 0, 0));
    rtE = 0;
    expect_out(idle(1));

    // branch against E producer, then M forward
    clr(); branchD = 1; rsD = 4; regwriteE = 1; writeregE = 4;
    expect_out(mk(0, 0, 2'b00, 2'b00, 1, 0, 5'b00100, 0, 0, 1));
    regwriteE = 0; writeregE = 0; writeregM = 4; regwriteM = 1;
    expect_out(mk(1, 0, 2'b00, 2'b00, 0, 0, 5'b00000, 0, 0, 2));
    clr(); jrD = 1; rtD = 6; writeregM = 6; memtoregM = 1; regwriteM = 1;
    expect_out(mk(0, 1, 2'b00, 2'b00, 1, 0, 5'b00100, 0, 0, 2));
    clr(); branchD = 1; regwriteE = 1; memtoregE = 1;
    expect_out(idle(3));

    // full divide: stall 5 cycles, busy 4, done in cycle 5, stall_cnt wraps 7 -> 0
    clr(); div_startE = 1;
    expect_out(divs(0, 3));
    expect_out(divs(1, 4));
    expect_out(divs(1, 5));
    expect_out(divs(1, 6));
    expect_out(divs(1, 7));
    expect_out(mk(0, 0, 2'b00, 2'b00, 0, 0, 5'b00000, 0, 1, 0));
    div_startE = 0;
    expect_out(idle(0));

    // exception in BUSY at cycle 2
    div_startE = 1;
    expect_out(divs(0, 0));
    expect_out(divs(1, 1));
    exceptM = 1;
    expect_out(mk(0, 0, 2'b00, 2'b00, 0, 0, 5'b11110, 1, 0, 2));
    exceptM = 0; div_startE = 0;
    expect_out(idle(2));
    expect_out(idle(2));

    // exception and start together: FSM stays IDLE
    exceptM = 1; div_startE = 1;
    expect_out(mk(0, 0, 2'b00, 2'b00, 0, 0, 5'b11110, 0, 0, 2));
    clr();
    expect_out(idle(2));

    // reset mid-BUSY
    div_startE = 1;
    expect_out(divs(0, 2));
    expect_out(divs(1, 3));
    rst = 1;
    expect_out(mk(0, 0, 2'b00, 2'b00, 0, 0, 5'b11111, 1, 0, 4));
    rst = 0; div_startE = 0;
    expect_out(idle(0));
    expect_out(idle(0));

    // load-use while divider busy: divide stall dominates, E held not flushed
    div_startE = 1;
    expect_out(divs(0, 0));
    memtoregE = 1; rtE = 9; rsD = 9;
    expect_out(divs(1, 1));
    clr(); div_startE = 1;
    expect_out(divs(1, 2));
    expect_out(divs(1, 3));
    expect_out(divs(1, 4));
    expect_out(mk(0, 0, 2'b00, 2'b00, 0, 0, 5'b00000, 0, 1, 5));
    div_startE = 0;
    expect_out(idle(5));

    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
